axi_rr_arbiter: RTL and testbench

- Parametrised successor to the fixed two-port IFU/LSU AXI arbiter.
- Arbitrates NUM_MASTERS request ports onto one AXI4 master port using round-robin priority.
- Supports INCR bursts of up to 256 beats, with configurable address, data and ID widths.
- One transaction is in flight at a time (read or write). Sits between the L1 caches/LSU and the SoC AXI interconnect.

---
 rtl/axi_rr_arbiter_if.sv | 69 ++++++
 rtl/axi_rr_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rr_arbiter_if.sv
// AXI4 master-side bus between the round-robin arbiter and the SoC interconnect.
// The arbiter uses the master modport; the interconnect or slave model uses the slave modport.
interface axi_rr_arbiter_if #(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 64,
  parameter int unsigned ID_WD   = 4
);
  localparam int unsigned STRB_WD = DATA_WD / 8;

  logic [ID_WD-1:0]   arid;
  logic [ADDR_WD-1:0] araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid;
  logic               arready;

  logic [ID_WD-1:0]   rid;
  logic [DATA_WD-1:0] rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  logic [ID_WD-1:0]   awid;
  logic [ADDR_WD-1:0] awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid;
  logic               awready;

  logic [DATA_WD-1:0] wdata;
  logic [STRB_WD-1:0] wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic [ID_WD-1:0]   bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter of NUM_MASTERS request ports onto one AXI4 master port.
// It keeps a single read or write burst in flight, and the AXI ID of each burst is the granted port index.
module axi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WD     = 32,
  parameter int unsigned DATA_WD     = 64,
  parameter int unsigned ID_WD       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_MASTERS-1:0]              m_req_valid,
  output logic [NUM_MASTERS-1:0]              m_req_ready,
  input  logic [NUM_MASTERS-1:0]              m_req_write,
  input  logic [NUM_MASTERS*ADDR_WD-1:0]      m_req_addr,
  input  logic [NUM_MASTERS*8-1:0]            m_req_len,
  input  logic [NUM_MASTERS*3-1:0]            m_req_size,
  input  logic [NUM_MASTERS-1:0]              m_wvalid,
  output logic [NUM_MASTERS-1:0]              m_wready,
  input  logic [NUM_MASTERS*DATA_WD-1:0]      m_wdata,
  input  logic [NUM_MASTERS*(DATA_WD/8)-1:0]  m_wstrb,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  input  logic [NUM_MASTERS-1:0]              m_rready,
  output logic [DATA_WD-1:0]                  m_rdata,
  output logic                                m_rlast,
  output logic [NUM_MASTERS-1:0]              m_bvalid,
  output logic [1:0]                          m_resp,
  output logic                                err,
  axi_rr_arbiter_if.master                    axi
);
  localparam int unsigned STRB_WD = DATA_WD / 8;
  localparam int unsigned PTR_WD  = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t              state;
  logic [PTR_WD-1:0]   rr_ptr;
  logic [PTR_WD-1:0]   gnt_q;
  logic [ADDR_WD-1:0]  addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic                arvalid_q;
  logic                awvalid_q;
  logic                bready_q;
  logic                aw_done;
  logic                w_done;
  logic [7:0]          beat_cnt;

  logic [ADDR_WD-1:0]  addr_a  [NUM_MASTERS];
  logic [7:0]          len_a   [NUM_MASTERS];
  logic [2:0]          size_a  [NUM_MASTERS];
  logic [DATA_WD-1:0]  wdata_a [NUM_MASTERS];
  logic [STRB_WD-1:0]  wstrb_a [NUM_MASTERS];

  logic                gnt_found;
  logic [PTR_WD-1:0]   gnt_idx;
  logic [PTR_WD-1:0]   cand;
  logic                r_hs;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;

  // Split the flat per-port buses into arrays indexed by port number
  always_comb begin
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      addr_a[i]  = m_req_addr[i*ADDR_WD +: ADDR_WD];
      len_a[i]   = m_req_len[i*8 +: 8];
      size_a[i]  = m_req_size[i*3 +: 3];
      wdata_a[i] = m_wdata[i*DATA_WD +: DATA_WD];
      wstrb_a[i] = m_wstrb[i*STRB_WD +: STRB_WD];
    end
  end

  // The first requesting port after rr_ptr, with wrap-around, wins the grant
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = PTR_WD'((32'(rr_ptr) + k) % NUM_MASTERS);
      if (!gnt_found && m_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign axi.arid    = ID_WD'(gnt_q);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state == S_R) && m_rready[gnt_q];

  assign axi.awid    = ID_WD'(gnt_q);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = (state == S_WR) && m_wvalid[gnt_q] && !w_done;
  assign axi.wdata   = wdata_a[gnt_q];
  assign axi.wstrb   = wstrb_a[gnt_q];
  assign axi.wlast   = (state == S_WR) && (beat_cnt == len_q);
  assign axi.bready  = bready_q;

  assign r_hs  = (state == S_R) && axi.rvalid && axi.rready;
  assign aw_hs = awvalid_q && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign b_hs  = (state == S_B) && bready_q && axi.bvalid;

  assign m_rdata = (state == S_R) ? axi.rdata : '0;
  assign m_rlast = (state == S_R) && axi.rlast;
  assign m_resp  = (state == S_R) ? axi.rresp :
                   (state == S_B) ? axi.bresp : 2'b00;

  // Only the granted port ever sees a ready, valid or completion strobe
  always_comb begin
    m_req_ready = '0;
    m_wready    = '0;
    m_rvalid    = '0;
    m_bvalid    = '0;
    if (state == S_IDLE && gnt_found) m_req_ready[gnt_idx] = 1'b1;
    if (state == S_WR && !w_done)     m_wready[gnt_q]      = axi.wready;
    if (state == S_R)                 m_rvalid[gnt_q]      = axi.rvalid;
    if (state == S_B)                 m_bvalid[gnt_q]      = axi.bvalid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_WD'(NUM_MASTERS - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_found) begin
            gnt_q  <= gnt_idx;
            rr_ptr <= gnt_idx;
            addr_q <= addr_a[gnt_idx];
            len_q  <= len_a[gnt_idx];
            size_q <= size_a[gnt_idx];
            if (m_req_write[gnt_idx]) begin
              state     <= S_WR;
              awvalid_q <= 1'b1;
            end else begin
              state     <= S_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            if (axi.rid != ID_WD'(gnt_q)) err <= 1'b1;
            if (axi.rlast) state <= S_IDLE;
          end
        end
        S_WR: begin
          // AW and W channels finish independently, in either order
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (axi.wlast) w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || (w_hs && axi.wlast))) begin
            state    <= S_B;
            bready_q <= 1'b1;
          end
        end
        S_B: begin
          if (b_hs) begin
            if (axi.bid != ID_WD'(gnt_q)) err <= 1'b1;
            bready_q <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat_cnt <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter with two request ports and a hand-driven AXI slave.
module tb_axi_rr_arbiter;
  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_req_valid;
  logic [NM-1:0]     m_req_ready;
  logic [NM-1:0]     m_req_write;
  logic [NM*AW-1:0]  m_req_addr;
  logic [NM*8-1:0]   m_req_len;
  logic [NM*3-1:0]   m_req_size;
  logic [NM-1:0]     m_wvalid;
  logic [NM-1:0]     m_wready;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*SW-1:0]  m_wstrb;
  logic [NM-1:0]     m_rvalid;
  logic [NM-1:0]     m_rready;
  logic [DW-1:0]     m_rdata;
  logic              m_rlast;
  logic [NM-1:0]     m_bvalid;
  logic [1:0]        m_resp;
  logic              err;

  int checks = 0;
  int errors = 0;

  axi_rr_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW), .ID_WD(IW)) axi ();

  axi_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WD(AW), .DATA_WD(DW), .ID_WD(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_write (m_req_write),
    .m_req_addr  (m_req_addr),
    .m_req_len   (m_req_len),
    .m_req_size  (m_req_size),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .m_rdata     (m_rdata),
    .m_rlast     (m_rlast),
    .m_bvalid    (m_bvalid),
    .m_resp      (m_resp),
    .err         (err),
    .axi         (axi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    m_req_write[p]         = wr;
    m_req_addr[p*AW +: AW] = addr;
    m_req_len[p*8 +: 8]    = len;
    m_req_size[p*3 +: 3]   = size;
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = 2'b00;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    m_req_valid = '0;
    m_req_write = '0;
    m_req_addr  = '0;
    m_req_len   = '0;
    m_req_size  = '0;
    m_wvalid    = '0;
    m_wdata     = '0;
    m_wstrb     = '1;
    m_rready    = '0;
    slave_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int beats;
    int cyc;
    logic [1:0] oh;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_arvalid", axi.arvalid, 1'b0);
    check_eq("rst_awvalid", axi.awvalid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_req_ready", m_req_ready, 2'b00);

    // Single read from port 1
    set_req(1, 1'b0, 32'h8000_0000, 8'd0, 3'd3);
    m_req_valid = 2'b10;
    #1;
    check_eq("rd_req_ready", m_req_ready, 2'b10);
    tick();
    m_req_valid = '0;
    #1;
    check_eq("rd_arvalid", axi.arvalid, 1'b1);
    check_eq("rd_arid", axi.arid, 4'd1);
    check_eq("rd_arlen", axi.arlen, 8'd0);
    check_eq("rd_arsize", axi.arsize, 3'd3);
    check_eq("rd_araddr", axi.araddr, 32'h8000_0000);
    check_eq("rd_arburst", axi.arburst, 2'b01);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 64'h1122_3344_5566_7788;
    axi.rlast   = 1'b1;
    axi.rid     = 4'd1;
    m_rready    = 2'b10;
    #1;
    check_eq("rd_arvalid_drop", axi.arvalid, 1'b0);
    check_eq("rd_m_rvalid", m_rvalid, 2'b10);
    check_eq("rd_m_rdata", m_rdata, 64'h1122_3344_5566_7788);
    check_eq("rd_m_rlast", m_rlast, 1'b1);
    check_eq("rd_rready", axi.rready, 1'b1);
    tick();
    slave_idle();
    m_rready = '0;
    #1;
    check_eq("rd_idle_rvalid", m_rvalid, 2'b00);
    check_eq("rd_idle_rdata", m_rdata, 64'd0);
    check_eq("rd_err", err, 1'b0);

    // Burst write from port 0, awready delayed until the fifth cycle
    set_req(0, 1'b1, 32'h0000_1000, 8'd3, 3'd3);
    m_req_valid = 2'b01;
    #1;
    check_eq("wr_req_ready", m_req_ready, 2'b01);
    tick();
    m_req_valid = '0;
    axi.wready  = 1'b1;
    m_wvalid    = 2'b01;
    beats = 0;
    cyc   = 0;
    while (!axi.bready && cyc < 20) begin
      m_wdata[0 +: DW] = 64'hA5A5_0000_0000_0000 | 64'(beats);
      axi.awready = (cyc == 5);
      #1;
      if (cyc == 4) check_eq("wr_wvalid_after_last", axi.wvalid, 1'b0);
      if (cyc == 5) check_eq("wr_awvalid_held", axi.awvalid, 1'b1);
      if (axi.wvalid && axi.wready) begin
        check_eq("wr_wdata", axi.wdata, 64'hA5A5_0000_0000_0000 | 64'(beats));
        check_eq("wr_wlast", axi.wlast, beats == 3);
        check_eq("wr_m_wready", m_wready, 2'b01);
        beats++;
      end
      tick();
      cyc++;
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    m_wvalid    = '0;
    check_eq("wr_beats", 64'(beats), 64'd4);
    check_eq("wr_b_entry_cyc", 64'(cyc), 64'd6);
    check_eq("wr_awvalid_drop", axi.awvalid, 1'b0);
    axi.bvalid = 1'b1;
    axi.bid    = 4'd0;
    axi.bresp  = 2'b00;
    axi.rresp  = 2'b11;
    #1;
    check_eq("wr_m_bvalid", m_bvalid, 2'b01);
    check_eq("wr_bresp", m_resp, 2'b00);
    tick();
    slave_idle();
    #1;
    check_eq("wr_m_bvalid_pulse", m_bvalid, 2'b00);
    check_eq("wr_bready_drop", axi.bready, 1'b0);

    // Round-robin between two continuously requesting ports
    do_reset();
    set_req(0, 1'b0, 32'h0000_0100, 8'd0, 3'd3);
    set_req(1, 1'b0, 32'h0000_0200, 8'd0, 3'd3);
    m_req_valid = 2'b11;
    m_rready    = 2'b11;
    for (int t = 0; t < 4; t++) begin
      oh = 2'b01 << (t % 2);
      #1;
      check_eq("rr_grant", m_req_ready, oh);
      tick();
      axi.arready = 1'b1;
      #1;
      check_eq("rr_arid", axi.arid, 4'(t % 2));
      check_eq("rr_busy_no_ready", m_req_ready, 2'b00);
      tick();
      axi.arready = 1'b0;
      axi.rvalid  = 1'b1;
      axi.rlast   = 1'b1;
      axi.rid     = 4'(t % 2);
      axi.rdata   = 64'(t);
      #1;
      check_eq("rr_m_rvalid", m_rvalid, oh);
      tick();
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
    end
    m_req_valid = '0;
    m_rready    = '0;

    // Read burst of 8 beats with m_rready toggling every cycle
    set_req(1, 1'b0, 32'h0000_3000, 8'd7, 3'd3);
    m_req_valid = 2'b10;
    #1;
    check_eq("bp_req_ready", m_req_ready, 2'b10);
    tick();
    m_req_valid = '0;
    axi.arready = 1'b1;
    #1;
    check_eq("bp_arlen", axi.arlen, 8'd7);
    tick();
    axi.arready = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 40) begin
      m_rready   = 2'b01 | (((cyc % 2) == 0) ? 2'b10 : 2'b00);
      axi.rvalid = 1'b1;
      axi.rid    = 4'd1;
      axi.rdata  = 64'h0000_D000 + 64'(beats);
      axi.rlast  = (beats == 7);
      #1;
      check_eq("bp_rready", axi.rready, m_rready[1]);
      check_eq("bp_m_rvalid", m_rvalid, 2'b10);
      if (axi.rready) begin
        check_eq("bp_rdata", m_rdata, 64'h0000_D000 + 64'(beats));
        beats++;
      end
      tick();
      cyc++;
    end
    slave_idle();
    m_rready = '0;
    #1;
    check_eq("bp_beats", 64'(beats), 64'd8);
    check_eq("bp_cycles", 64'(cyc), 64'd15);
    check_eq("bp_idle_rvalid", m_rvalid, 2'b00);
    check_eq("bp_err", err, 1'b0);

    // Wrong rid on a read granted to port 0
    do_reset();
    set_req(0, 1'b0, 32'h0000_4000, 8'd0, 3'd3);
    m_req_valid = 2'b01;
    #1;
    check_eq("id_req_ready", m_req_ready, 2'b01);
    tick();
    m_req_valid = '0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rlast   = 1'b1;
    axi.rid     = 4'd3;
    axi.rdata   = 64'hCAFE_F00D_0000_0001;
    m_rready    = 2'b01;
    #1;
    check_eq("id_m_rvalid", m_rvalid, 2'b01);
    check_eq("id_m_rdata", m_rdata, 64'hCAFE_F00D_0000_0001);
    check_eq("id_err_before", err, 1'b0);
    tick();
    slave_idle();
    m_rready = '0;
    #1;
    check_eq("id_err_set", err, 1'b1);
    tick();
    tick();
    tick();
    check_eq("id_err_sticky", err, 1'b1);

    // Reset in the middle of a len=7 write after three beats
    set_req(0, 1'b1, 32'h0000_5000, 8'd7, 3'd3);
    m_req_valid = 2'b01;
    #1;
    check_eq("mr_req_ready", m_req_ready, 2'b01);
    tick();
    m_req_valid = '0;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    m_wvalid    = 2'b01;
    for (int b = 0; b < 3; b++) begin
      m_wdata[0 +: DW] = 64'(b);
      #1;
      check_eq("mr_wbeat", axi.wvalid, 1'b1);
      tick();
      axi.awready = 1'b0;
    end
    reset = 1'b1;
    slave_idle();
    tick();
    reset = 1'b0;
    #1;
    check_eq("mr_arvalid", axi.arvalid, 1'b0);
    check_eq("mr_awvalid", axi.awvalid, 1'b0);
    check_eq("mr_wvalid", axi.wvalid, 1'b0);
    check_eq("mr_wlast", axi.wlast, 1'b0);
    check_eq("mr_bready", axi.bready, 1'b0);
    check_eq("mr_m_wready", m_wready, 2'b00);
    check_eq("mr_err", err, 1'b0);
    m_wvalid = '0;
    set_req(1, 1'b0, 32'h0000_6000, 8'd0, 3'd3);
    m_req_valid = 2'b11;
    #1;
    check_eq("mr_next_grant", m_req_ready, 2'b01);
    tick();
    m_req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
